// File: rtl/sd_card_data_phy.sv
`default_nettype none
// ============================================================================
// sd_card_data_phy : card-side 4-bit SD DAT bus responder (block receive with
//                    CRC status token and busy, block send with per-line CRC16)
// Revision 1.0
// ============================================================================
module sd_card_data_phy #(
  parameter int BLOCK_BYTES = 512,
  parameter int NAC_CYCLES  = 2,
  parameter int BUSY_CYCLES = 8
) (
  input  logic       sd_clk,
  input  logic       rst,
  output logic       DAT_oe_o,
  output logic [3:0] DAT_dat_o,
  input  logic [3:0] DAT_dat_i,
  input  logic [1:0] start_dat,
  input  logic [7:0] tx_dat_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic [7:0] rx_dat_o,
  output logic       rx_valid_o,
  output logic       crc_err_o,
  output logic       tx_underrun_o,
  output logic       busy_o,
  output logic       done_o
);

  localparam int CW = $clog2(2*BLOCK_BYTES+1);
  localparam logic [CW-1:0] LAST_NIB  = CW'(2*BLOCK_BYTES-1);
  localparam logic [CW-1:0] LAST_CRC  = CW'(15);
  localparam logic [CW-1:0] LAST_GAP  = CW'(1);
  localparam logic [CW-1:0] LAST_TOK  = CW'(4);
  localparam logic [CW-1:0] LAST_BUSY = CW'(BUSY_CYCLES-1);
  localparam logic [CW-1:0] NAC_MIN   = CW'(NAC_CYCLES);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_RX_WAIT  = 4'd1;
  localparam logic [3:0] S_RX_DATA  = 4'd2;
  localparam logic [3:0] S_RX_CRC   = 4'd3;
  localparam logic [3:0] S_RX_END   = 4'd4;
  localparam logic [3:0] S_TOK_GAP  = 4'd5;
  localparam logic [3:0] S_TOKEN    = 4'd6;
  localparam logic [3:0] S_BUSY     = 4'd7;
  localparam logic [3:0] S_TX_NAC   = 4'd8;
  localparam logic [3:0] S_TX_START = 4'd9;
  localparam logic [3:0] S_TX_DATA  = 4'd10;
  localparam logic [3:0] S_TX_CRC   = 4'd11;
  localparam logic [3:0] S_TX_END   = 4'd12;

  logic [3:0]    state;
  logic [3:0]    state_nxt;
  logic [CW-1:0] cnt;
  logic          drive_oe;
  logic [3:0]    drive_dat;
  logic [3:0]    low_nib;
  logic [7:0]    hold;
  logic          crc_bad;
  logic          crc_clr;
  logic          crc_en;
  logic [3:0]    crc_din;
  logic [3:0]    crc_bit;
  logic [3:0]    crc_idx;
  logic          start_go;

  function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic d);
    logic fb;
    fb = c[15] ^ d;
    return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  assign busy_o   = (state != S_IDLE);
  assign start_go = (state == S_IDLE) && ((start_dat == 2'b01) || (start_dat == 2'b10));
  assign crc_idx  = 4'hF - cnt[3:0];
  assign crc_clr  = (state == S_IDLE) || (state == S_RX_WAIT) ||
                    (state == S_TX_NAC) || (state == S_TX_START);
  assign crc_en   = (state == S_RX_DATA) || (state == S_TX_DATA);
  // Send CRC follows what actually went out on the wire, including underrun zeros.
  assign crc_din  = (state == S_RX_DATA) ? DAT_dat_i : DAT_dat_o;

  for (genvar i = 0; i < 4; i++) begin : g_lane
    logic [15:0] crc;
    always_ff @(posedge sd_clk or posedge rst) begin
      if (rst)          crc <= '0;
      else if (crc_clr) crc <= '0;
      else if (crc_en)  crc <= crc16_step(crc, crc_din[i]);
    end
    assign crc_bit[i] = crc[crc_idx];
  end

  always_ff @(posedge sd_clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (start_dat == 2'b11) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_dat == 2'b01)      state_nxt = S_RX_WAIT;
          else if (start_dat == 2'b10) state_nxt = S_TX_NAC;
        end
        S_RX_WAIT:  if (!DAT_dat_i[0])          state_nxt = S_RX_DATA;
        S_RX_DATA:  if (cnt == LAST_NIB)        state_nxt = S_RX_CRC;
        S_RX_CRC:   if (cnt == LAST_CRC)        state_nxt = S_RX_END;
        S_RX_END:                               state_nxt = S_TOK_GAP;
        S_TOK_GAP:  if (cnt == LAST_GAP)        state_nxt = S_TOKEN;
        S_TOKEN:    if (cnt == LAST_TOK)        state_nxt = S_BUSY;
        S_BUSY:     if (cnt == LAST_BUSY)       state_nxt = S_IDLE;
        S_TX_NAC:   if (cnt >= NAC_MIN && tx_valid_i) state_nxt = S_TX_START;
        S_TX_START:                             state_nxt = S_TX_DATA;
        S_TX_DATA:  if (cnt == LAST_NIB)        state_nxt = S_TX_CRC;
        S_TX_CRC:   if (cnt == LAST_CRC)        state_nxt = S_TX_END;
        S_TX_END:                               state_nxt = S_IDLE;
        default:                                state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    drive_oe   = 1'b0;
    drive_dat  = 4'h0;
    tx_ready_o = 1'b0;
    case (state)
      S_TOKEN: begin
        drive_oe = 1'b1;
        if (cnt == '0)            drive_dat = 4'b1110;
        else if (cnt == LAST_TOK) drive_dat = 4'b1111;
        else                      drive_dat = {3'b111, crc_err_o ^ (cnt == CW'(2))};
      end
      S_BUSY: begin
        drive_oe  = 1'b1;
        drive_dat = 4'b1110;
      end
      S_TX_NAC: tx_ready_o = (cnt >= NAC_MIN);
      S_TX_START: begin
        drive_oe  = 1'b1;
        drive_dat = 4'h0;
      end
      S_TX_DATA: begin
        drive_oe   = 1'b1;
        drive_dat  = cnt[0] ? hold[7:4] : hold[3:0];
        // High nibble is latched on this cycle's negedge, so the holding register is free.
        tx_ready_o = cnt[0] && (cnt != LAST_NIB);
      end
      S_TX_CRC: begin
        drive_oe  = 1'b1;
        drive_dat = crc_bit;
      end
      S_TX_END: begin
        drive_oe  = 1'b1;
        drive_dat = 4'hF;
      end
      default: ;
    endcase
  end

  // TX_NAC starts at one because the cycle that decoded the start already counts.
  always_ff @(posedge sd_clk or posedge rst) begin
    if (rst)                     cnt <= '0;
    else if (state_nxt != state) cnt <= (state_nxt == S_TX_NAC) ? CW'(1) : '0;
    else if (cnt != '1)          cnt <= cnt + CW'(1);
  end

  always_ff @(negedge sd_clk or posedge rst) begin
    if (rst) begin
      DAT_oe_o  <= 1'b0;
      DAT_dat_o <= 4'h0;
    end else begin
      DAT_oe_o  <= drive_oe;
      DAT_dat_o <= drive_dat;
    end
  end

  always_ff @(posedge sd_clk or posedge rst) begin
    if (rst) begin
      rx_dat_o      <= '0;
      rx_valid_o    <= 1'b0;
      low_nib       <= '0;
      hold          <= '0;
      crc_bad       <= 1'b0;
      crc_err_o     <= 1'b0;
      tx_underrun_o <= 1'b0;
      done_o        <= 1'b0;
    end else begin
      rx_valid_o <= 1'b0;
      done_o     <= ((state == S_BUSY) || (state == S_TX_END)) &&
                    (state_nxt == S_IDLE) && (start_dat != 2'b11);
      if (start_go) begin
        crc_err_o     <= 1'b0;
        tx_underrun_o <= 1'b0;
      end
      case (state)
        S_RX_WAIT: crc_bad <= 1'b0;
        S_RX_DATA: begin
          if (!cnt[0]) begin
            low_nib <= DAT_dat_i;
          end else begin
            rx_dat_o   <= {DAT_dat_i, low_nib};
            rx_valid_o <= 1'b1;
          end
        end
        S_RX_CRC: if (DAT_dat_i != crc_bit) crc_bad <= 1'b1;
        S_RX_END: crc_err_o <= crc_bad | (DAT_dat_i != 4'hF);
        S_TX_NAC: if (tx_ready_o && tx_valid_i) hold <= tx_dat_i;
        S_TX_DATA: begin
          if (tx_ready_o) begin
            hold <= tx_valid_i ? tx_dat_i : 8'h00;
            if (!tx_valid_i) tx_underrun_o <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
